serv_ram32_arb: RTL and testbench

//  Two-port arbiter sharing one single-port RAM32 macro (32x32, 1-cycle read latency) between

---
 rtl/serv_ram32_arb_pkg.sv | 15 +
 rtl/serv_ram32_arb_if.sv | 50 +++++
 rtl/serv_ram32_arb_starve.sv | 30 +++
 rtl/serv_ram32_arb.sv | 102 ++++++++++
 tb/tb_serv_ram32_arb.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/serv_ram32_arb_pkg.sv
// Shared types and constants for the RAM32 two-port arbiter.
// The RAM32_ARB_STARVE_GUARD_EN macro enables starvation protection for port B.
package serv_ram32_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

  localparam int unsigned RAM_WORDS = 32;
  localparam int unsigned RAM_AW    = 5;
  localparam logic [3:0]  BE_ALL    = 4'hF;

endpackage

// File: rtl/serv_ram32_arb_if.sv
// Bundle of requester A/B buses and RAM32 macro pins.
// The slave modport is the arbiter view; the master modport drives requests and RAM read data.
interface serv_ram32_arb_if
  import serv_ram32_arb_pkg::*;
#(
  parameter int unsigned AW = 5
);

  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [31:0]   a_wdata;
  logic          a_gnt;
  logic          a_rvalid;
  logic [31:0]   a_rdata;

  logic          b_req;
  logic          b_we;
  logic [3:0]    b_be;
  logic [AW-1:0] b_addr;
  logic [31:0]   b_wdata;
  logic          b_gnt;
  logic          b_rvalid;
  logic [31:0]   b_rdata;

  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [3:0]        ram_we;
  logic              ram_en;
  logic [31:0]       ram_dout;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_be, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output ram_addr, ram_din, ram_we, ram_en,
    input  ram_dout
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_be, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  ram_addr, ram_din, ram_we, ram_en,
    output ram_dout
  );

endinterface

// File: rtl/serv_ram32_arb_starve.sv
// Counts consecutive A grants while B waits; raises force_b once STARVE_MAX is reached.
// Only instantiated when RAM32_ARB_STARVE_GUARD_EN is defined.
module serv_ram32_arb_starve #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_gnt,
  input  logic b_req,
  input  logic b_gnt,
  output logic force_b
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (b_gnt || !b_req) begin
      cnt <= '0;
    end else if (a_gnt) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign force_b = (cnt == CW'(STARVE_MAX));

endmodule

// File: rtl/serv_ram32_arb.sv
// Arbitrates one single-port RAM32 between port A (high priority) and port B, steering
// read data back to the issuing port. Define RAM32_ARB_STARVE_GUARD_EN to bound B starvation.
module serv_ram32_arb
  import serv_ram32_arb_pkg::*;
#(
  parameter int unsigned AW         = 5,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic               i_clk,
  input logic               i_rst_n,
  serv_ram32_arb_if.slave   bus
);

  logic        a_gnt;
  logic        b_gnt;
  logic        force_b;
  owner_e      owner;
  logic        a_rvalid;
  logic        b_rvalid;
  logic [31:0] a_hold;
  logic [31:0] b_hold;

`ifdef RAM32_ARB_STARVE_GUARD_EN
  serv_ram32_arb_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .a_gnt   (a_gnt),
    .b_req   (bus.b_req),
    .b_gnt   (b_gnt),
    .force_b (force_b)
  );
`else
  assign force_b = 1'b0;
`endif

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (i_rst_n) begin
      if (bus.a_req && !(bus.b_req && force_b)) begin
        a_gnt = 1'b1;
      end else if (bus.b_req) begin
        b_gnt = 1'b1;
      end
    end
  end

  // Upper address bits beyond the RAM depth are dropped.
  always_comb begin
    bus.ram_en   = 1'b0;
    bus.ram_we   = '0;
    bus.ram_addr = '0;
    bus.ram_din  = '0;
    if (a_gnt) begin
      bus.ram_en   = 1'b1;
      bus.ram_we   = bus.a_we ? BE_ALL : '0;
      bus.ram_addr = bus.a_addr[RAM_AW-1:0];
      bus.ram_din  = bus.a_wdata;
    end else if (b_gnt) begin
      bus.ram_en   = 1'b1;
      bus.ram_we   = bus.b_we ? bus.b_be : '0;
      bus.ram_addr = bus.b_addr[RAM_AW-1:0];
      bus.ram_din  = bus.b_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      owner <= OWN_NONE;
    end else if (a_gnt && !bus.a_we) begin
      owner <= OWN_A;
    end else if (b_gnt && !bus.b_we) begin
      owner <= OWN_B;
    end else begin
      owner <= OWN_NONE;
    end
  end

  // Gating with reset drops a read that was in flight when reset asserted.
  assign a_rvalid = i_rst_n && (owner == OWN_A);
  assign b_rvalid = i_rst_n && (owner == OWN_B);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      a_hold <= '0;
      b_hold <= '0;
    end else begin
      if (a_rvalid) a_hold <= bus.ram_dout;
      if (b_rvalid) b_hold <= bus.ram_dout;
    end
  end

  assign bus.a_gnt    = a_gnt;
  assign bus.b_gnt    = b_gnt;
  assign bus.a_rvalid = a_rvalid;
  assign bus.b_rvalid = b_rvalid;
  assign bus.a_rdata  = a_rvalid ? bus.ram_dout : a_hold;
  assign bus.b_rdata  = b_rvalid ? bus.ram_dout : b_hold;

endmodule

// File: tb/tb_serv_ram32_arb.sv
// Directed, table-driven bench for serv_ram32_arb with a behavioural RAM32 model.
// Honours RAM32_ARB_STARVE_GUARD_EN to select the contention expectation.
module tb_serv_ram32_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  serv_ram32_arb_if #(.AW(5)) bus ();

  serv_ram32_arb #(
    .AW         (5),
    .STARVE_MAX (4)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Behavioural RAM32: byte-enabled writes, 1-cycle registered read when we==0.
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.ram_we[i]) mem[bus.ram_addr][i*8 +: 8] <= bus.ram_din[i*8 +: 8];
      end
      if (bus.ram_we == 4'h0) bus.ram_dout <= mem[bus.ram_addr];
    end
  end

  typedef struct {
    logic        a_req;
    logic        a_we;
    logic [4:0]  a_addr;
    logic [31:0] a_wdata;
    logic        b_req;
    logic        b_we;
    logic [3:0]  b_be;
    logic [4:0]  b_addr;
    logic [31:0] b_wdata;
    logic [1:0]  gnt;
    logic        en;
    logic [3:0]  we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [1:0]  rv;
    logic [31:0] a_rd;
    logic [31:0] b_rd;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.a_req   = v.a_req;
    bus.a_we    = v.a_we;
    bus.a_addr  = v.a_addr;
    bus.a_wdata = v.a_wdata;
    bus.b_req   = v.b_req;
    bus.b_we    = v.b_we;
    bus.b_be    = v.b_be;
    bus.b_addr  = v.b_addr;
    bus.b_wdata = v.b_wdata;
  endtask

  task automatic idle();
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_be = '0; bus.b_addr = '0; bus.b_wdata = '0;
  endtask

  initial begin
    //         a_req a_we a_addr a_wdata        b_req b_we b_be  b_addr b_wdata        gnt    en   we    addr   din            rv     a_rd           b_rd
    vecs[0]  = '{1'b1,1'b1,5'd5,32'hDEADBEEF, 1'b0,1'b0,4'h0,5'd0,32'h0,        2'b10,1'b1,4'hF,5'd5,32'hDEADBEEF, 2'b00,32'h0,        32'h0};
    vecs[1]  = '{1'b1,1'b0,5'd5,32'h0,        1'b0,1'b0,4'h0,5'd0,32'h0,        2'b10,1'b1,4'h0,5'd5,32'h0,        2'b00,32'h0,        32'h0};
    vecs[2]  = '{1'b0,1'b0,5'd0,32'h0,        1'b0,1'b0,4'h0,5'd0,32'h0,        2'b00,1'b0,4'h0,5'd0,32'h0,        2'b10,32'hDEADBEEF, 32'h0};
    vecs[3]  = '{1'b0,1'b0,5'd0,32'h0,        1'b0,1'b0,4'h0,5'd0,32'h0,        2'b00,1'b0,4'h0,5'd0,32'h0,        2'b00,32'hDEADBEEF, 32'h0};
    vecs[4]  = '{1'b0,1'b0,5'd0,32'h0,        1'b1,1'b1,4'hF,5'd3,32'hFFFFFFFF, 2'b01,1'b1,4'hF,5'd3,32'hFFFFFFFF, 2'b00,32'hDEADBEEF, 32'h0};
    vecs[5]  = '{1'b0,1'b0,5'd0,32'h0,        1'b1,1'b1,4'h3,5'd3,32'h1234ABCD, 2'b01,1'b1,4'h3,5'd3,32'h1234ABCD, 2'b00,32'hDEADBEEF, 32'h0};
    vecs[6]  = '{1'b0,1'b0,5'd0,32'h0,        1'b1,1'b0,4'hF,5'd3,32'h0,        2'b01,1'b1,4'h0,5'd3,32'h0,        2'b00,32'hDEADBEEF, 32'h0};
    vecs[7]  = '{1'b0,1'b0,5'd0,32'h0,        1'b0,1'b0,4'h0,5'd0,32'h0,        2'b00,1'b0,4'h0,5'd0,32'h0,        2'b01,32'hDEADBEEF, 32'hFFFFABCD};
    vecs[8]  = '{1'b0,1'b0,5'd0,32'h0,        1'b1,1'b1,4'h0,5'd3,32'h55555555, 2'b01,1'b1,4'h0,5'd3,32'h55555555, 2'b00,32'hDEADBEEF, 32'hFFFFABCD};
    vecs[9]  = '{1'b0,1'b0,5'd0,32'h0,        1'b0,1'b0,4'h0,5'd0,32'h0,        2'b00,1'b0,4'h0,5'd0,32'h0,        2'b00,32'hDEADBEEF, 32'hFFFFABCD};
    vecs[10] = '{1'b1,1'b1,5'd1,32'hA1A1A1A1, 1'b0,1'b0,4'h0,5'd0,32'h0,        2'b10,1'b1,4'hF,5'd1,32'hA1A1A1A1, 2'b00,32'hDEADBEEF, 32'hFFFFABCD};
    vecs[11] = '{1'b0,1'b0,5'd0,32'h0,        1'b1,1'b1,4'hF,5'd2,32'hB2B2B2B2, 2'b01,1'b1,4'hF,5'd2,32'hB2B2B2B2, 2'b00,32'hDEADBEEF, 32'hFFFFABCD};
    vecs[12] = '{1'b1,1'b0,5'd1,32'h0,        1'b0,1'b0,4'h0,5'd0,32'h0,        2'b10,1'b1,4'h0,5'd1,32'h0,        2'b00,32'hDEADBEEF, 32'hFFFFABCD};
    vecs[13] = '{1'b0,1'b0,5'd0,32'h0,        1'b1,1'b0,4'hF,5'd2,32'h0,        2'b01,1'b1,4'h0,5'd2,32'h0,        2'b10,32'hA1A1A1A1, 32'hFFFFABCD};
    vecs[14] = '{1'b0,1'b0,5'd0,32'h0,        1'b0,1'b0,4'h0,5'd0,32'h0,        2'b00,1'b0,4'h0,5'd0,32'h0,        2'b01,32'hA1A1A1A1, 32'hB2B2B2B2};
    vecs[15] = '{1'b0,1'b0,5'd0,32'h0,        1'b0,1'b0,4'h0,5'd0,32'h0,        2'b00,1'b0,4'h0,5'd0,32'h0,        2'b00,32'hA1A1A1A1, 32'hB2B2B2B2};
    vecs[16] = '{1'b1,1'b0,5'd5,32'h0,        1'b1,1'b0,4'hF,5'd3,32'h0,        2'b10,1'b1,4'h0,5'd5,32'h0,        2'b00,32'hA1A1A1A1, 32'hB2B2B2B2};
    vecs[17] = '{1'b1,1'b0,5'd1,32'h0,        1'b0,1'b0,4'h0,5'd0,32'h0,        2'b10,1'b1,4'h0,5'd1,32'h0,        2'b10,32'hDEADBEEF, 32'hB2B2B2B2};
    vecs[18] = '{1'b1,1'b0,5'd5,32'h0,        1'b0,1'b0,4'h0,5'd0,32'h0,        2'b10,1'b1,4'h0,5'd5,32'h0,        2'b10,32'hA1A1A1A1, 32'hB2B2B2B2};
    vecs[19] = '{1'b0,1'b0,5'd0,32'h0,        1'b0,1'b0,4'h0,5'd0,32'h0,        2'b00,1'b0,4'h0,5'd0,32'h0,        2'b10,32'hDEADBEEF, 32'hB2B2B2B2};
    vecs[20] = '{1'b0,1'b0,5'd0,32'h0,        1'b0,1'b0,4'h0,5'd0,32'h0,        2'b00,1'b0,4'h0,5'd0,32'h0,        2'b00,32'hDEADBEEF, 32'hB2B2B2B2};

    // Reset state with both requesters active
    idle();
    bus.a_req = 1'b1; bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_be = 4'hF;
    @(negedge clk);
    #1;
    check("rst_a_gnt", {31'd0, bus.a_gnt}, 32'd0);
    check("rst_b_gnt", {31'd0, bus.b_gnt}, 32'd0);
    check("rst_ram_en", {31'd0, bus.ram_en}, 32'd0);
    check("rst_ram_we", {28'd0, bus.ram_we}, 32'd0);
    check("rst_rvalid", {30'd0, bus.a_rvalid, bus.b_rvalid}, 32'd0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_gnt", i),    {30'd0, bus.a_gnt, bus.b_gnt}, {30'd0, vecs[i].gnt});
      check($sformatf("v%0d_en", i),     {31'd0, bus.ram_en}, {31'd0, vecs[i].en});
      check($sformatf("v%0d_we", i),     {28'd0, bus.ram_we}, {28'd0, vecs[i].we});
      check($sformatf("v%0d_addr", i),   {27'd0, bus.ram_addr}, {27'd0, vecs[i].addr});
      check($sformatf("v%0d_din", i),    bus.ram_din, vecs[i].din);
      check($sformatf("v%0d_rvalid", i), {30'd0, bus.a_rvalid, bus.b_rvalid}, {30'd0, vecs[i].rv});
      check($sformatf("v%0d_a_rdata", i), bus.a_rdata, vecs[i].a_rd);
      check($sformatf("v%0d_b_rdata", i), bus.b_rdata, vecs[i].b_rd);
    end

    // Continuous contention, both sides writing
    for (int k = 0; k < 20; k++) begin
      logic exp_b;
`ifdef RAM32_ARB_STARVE_GUARD_EN
      exp_b = ((k % 5) == 4);
`else
      exp_b = 1'b0;
`endif
      @(negedge clk);
      bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 5'd10; bus.a_wdata = 32'h0A0A0A0A;
      bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_be = 4'hF; bus.b_addr = 5'd11; bus.b_wdata = 32'h0B0B0B0B;
      #1;
      check($sformatf("cont%0d_a_gnt", k), {31'd0, bus.a_gnt}, {31'd0, !exp_b});
      check($sformatf("cont%0d_b_gnt", k), {31'd0, bus.b_gnt}, {31'd0, exp_b});
    end
    @(negedge clk);
    idle();

    // Reset while an A read is in flight
    @(negedge clk);
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 5'd5;
    #1;
    check("rr_a_gnt", {31'd0, bus.a_gnt}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rr_a_rvalid", {31'd0, bus.a_rvalid}, 32'd0);
    check("rr_ram_en", {31'd0, bus.ram_en}, 32'd0);
    check("rr_a_gnt_in_rst", {31'd0, bus.a_gnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    #1;
    check("rr_post_a_rvalid", {31'd0, bus.a_rvalid}, 32'd0);
    check("rr_post_a_hold", bus.a_rdata, 32'h0);
    check("rr_post_b_hold", bus.b_rdata, 32'h0);
    @(negedge clk);
    #1;
    check("rr_post2_rvalid", {30'd0, bus.a_rvalid, bus.b_rvalid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
